// File: rtl/enc_ctrl_pkg.sv
// Shared definitions for the encoder setpoint editor: FSM state encoding and BCD limits.
package enc_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StEdit   = 2'd1,
    StCommit = 2'd2,
    StAbort  = 2'd3
  } state_e;

  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam logic [3:0] BCD_MIN = 4'd0;
  localparam logic [1:0] SEL_MSD = 2'd3;

endpackage

// File: rtl/bcd_digit_step.sv
// Saturating +/-1 on a single BCD digit.
// Ports:
//   d   - current digit
//   up  - increment request (saturates at 9)
//   dn  - decrement request (saturates at 0)
//   out - resulting digit; up and dn together leave a valid digit unchanged,
//         and any step on an out-of-range digit (>9) yields 0
module bcd_digit_step
  import enc_ctrl_pkg::*;
(
  input  logic [3:0] d,
  input  logic       up,
  input  logic       dn,
  output logic [3:0] out
);

  always_comb begin
    out = d;
    if (up || dn) begin
      if (d > BCD_MAX) begin
        out = BCD_MIN;
      end else if (up && !dn) begin
        out = (d == BCD_MAX) ? d : d + 4'd1;
      end else if (dn && !up) begin
        out = (d == BCD_MIN) ? d : d - 4'd1;
      end
    end
  end

endmodule

// File: rtl/enc_setpoint_ctrl.sv
// 4-digit BCD setpoint editor driven by encoder step pulses and a button pulse.
// Ports:
//   clkin            - system clock
//   rst              - asynchronous active-low reset
//   step_up, step_dn - 1-cycle encoder step pulses
//   btn              - 1-cycle debounced button pulse
//   value            - committed setpoint, [15:12] = MSD
//   disp             - edit buffer while editing, value otherwise
//   sel              - selected digit index (3 = MSD), meaningful while editing
//   editing          - high in EDIT
//   blink            - blink phase of selected digit, 0 outside EDIT
//   commit, abort    - 1-cycle pulses on commit / timeout discard
// All outputs are registered and derived from the next state.
module enc_setpoint_ctrl
  import enc_ctrl_pkg::*;
#(
  parameter int unsigned NDIG        = 4,
  parameter int unsigned TIMEOUT_CYC = 5000,
  parameter int unsigned BLINK_HALF  = 250
) (
  input  logic              clkin,
  input  logic              rst,
  input  logic              step_up,
  input  logic              step_dn,
  input  logic              btn,
  output logic [4*NDIG-1:0] value,
  output logic [4*NDIG-1:0] disp,
  output logic [1:0]        sel,
  output logic              editing,
  output logic              blink,
  output logic              commit,
  output logic              abort
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned BW = $clog2(BLINK_HALF + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [BW-1:0] BLK_LAST = BW'(BLINK_HALF - 1);

  state_e              state_q, state_d;
  logic [4*NDIG-1:0]   value_q, value_d;
  logic [4*NDIG-1:0]   edit_q, edit_d;
  logic [4*NDIG-1:0]   disp_q, disp_d;
  logic [1:0]          sel_q, sel_d;
  logic                editing_q, editing_d;
  logic                blink_q, blink_d;
  logic                commit_q, commit_d;
  logic                abort_q, abort_d;
  logic [TW-1:0]       tmr_q, tmr_d;
  logic [BW-1:0]       bcnt_q, bcnt_d;

  logic [3:0] cur_dig, new_dig;

  assign cur_dig = edit_q[{sel_q, 2'b00} +: 4];

  bcd_digit_step u_step (
    .d   (cur_dig),
    .up  (step_up),
    .dn  (step_dn),
    .out (new_dig)
  );

  always_comb begin
    state_d  = state_q;
    value_d  = value_q;
    edit_d   = edit_q;
    sel_d    = sel_q;
    tmr_d    = tmr_q;
    bcnt_d   = bcnt_q;
    blink_d  = blink_q;
    commit_d = 1'b0;
    abort_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        tmr_d   = '0;
        bcnt_d  = '0;
        blink_d = 1'b0;
        if (btn) begin
          state_d = StEdit;
          edit_d  = value_q;
          sel_d   = SEL_MSD;
          blink_d = 1'b1;
        end
      end
      StEdit: begin
        // Priority: btn over steps, any event over timeout expiry.
        if (btn) begin
          tmr_d = '0;
          if (sel_q != 2'd0) begin
            sel_d = sel_q - 2'd1;
          end else begin
            state_d  = StCommit;
            commit_d = 1'b1;
            value_d  = edit_q;
          end
        end else if (step_up || step_dn) begin
          tmr_d = '0;
          edit_d[{sel_q, 2'b00} +: 4] = new_dig;
        end else if (tmr_q >= TMO_LAST) begin
          state_d = StAbort;
          abort_d = 1'b1;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end

        if (state_d != StEdit) begin
          blink_d = 1'b0;
          bcnt_d  = '0;
          tmr_d   = '0;
        end else if (sel_d != sel_q) begin
          // New digit selected: restart the phase visibly on.
          blink_d = 1'b1;
          bcnt_d  = '0;
        end else if (bcnt_q >= BLK_LAST) begin
          blink_d = ~blink_q;
          bcnt_d  = '0;
        end else begin
          bcnt_d = bcnt_q + 1'b1;
        end
      end
      StCommit, StAbort: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    editing_d = (state_d == StEdit);
    disp_d    = editing_d ? edit_d : value_d;
  end

  always_ff @(posedge clkin or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      value_q   <= '0;
      edit_q    <= '0;
      disp_q    <= '0;
      sel_q     <= SEL_MSD;
      editing_q <= 1'b0;
      blink_q   <= 1'b0;
      commit_q  <= 1'b0;
      abort_q   <= 1'b0;
      tmr_q     <= '0;
      bcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      value_q   <= value_d;
      edit_q    <= edit_d;
      disp_q    <= disp_d;
      sel_q     <= sel_d;
      editing_q <= editing_d;
      blink_q   <= blink_d;
      commit_q  <= commit_d;
      abort_q   <= abort_d;
      tmr_q     <= tmr_d;
      bcnt_q    <= bcnt_d;
    end
  end

  assign value   = value_q;
  assign disp    = disp_q;
  assign sel     = sel_q;
  assign editing = editing_q;
  assign blink   = blink_q;
  assign commit  = commit_q;
  assign abort   = abort_q;

endmodule
